// File: rtl/shift_unit_iter.sv
// Iterative shift/rotate unit: moves the operand up to STEP positions per clock until the count runs out.
// Optional registered zero flag on the result is built when SHIFT_ZERO_FLAG_EN is defined.
module shift_unit_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       dbg_state
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    // A transfer happens on a side only when valid and ready are both high at a rising edge;
    // valid may drop before acceptance, and once offered the result is held until out_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {OP_ROL = 2'd0, OP_SLL = 2'd1, OP_ROR = 2'd2, OP_SRA = 2'd3} op_t;

    localparam logic [CNT_W:0] STEP_L = (CNT_W+1)'(STEP);

    state_t           state, state_nxt;
    op_t              op;
    logic [WIDTH-1:0] work, shifted;
    logic [CNT_W-1:0] rem, rem_nxt, k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (in_cnt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (rem_nxt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The step never exceeds the remaining count, so the last step may be partial.
    always_comb begin
        k       = (({1'b0, rem}) < STEP_L) ? rem : STEP_L[CNT_W-1:0];
        rem_nxt = rem - k;
    end

    always_comb begin
        shifted = work;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k)) begin
                case (op)
                    OP_ROL:  shifted = {shifted[WIDTH-2:0], shifted[WIDTH-1]};
                    OP_SLL:  shifted = {shifted[WIDTH-2:0], 1'b0};
                    OP_ROR:  shifted = {shifted[0], shifted[WIDTH-1:1]};
                    default: shifted = {shifted[WIDTH-1], shifted[WIDTH-1:1]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            rem  <= '0;
            op   <= OP_ROL;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_data;
                        rem  <= in_cnt;
                        op   <= op_t'(in_op);
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    rem  <= rem_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef SHIFT_ZERO_FLAG_EN
    // Tracks the working register so it is valid in the same cycle as out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (in_valid) out_zero <= (in_data == '0);
                SHIFT:   out_zero <= (shifted == '0);
                default: ;
            endcase
        end
    end
`endif

    assign out_data  = work;
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench for shift_unit_iter: one instance with STEP=1 and one with STEP=4 share the input bus.
// Zero-flag checks are compiled in when SHIFT_ZERO_FLAG_EN is defined.
module tb_shift_unit_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v1 = 1'b0, v4 = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_cnt = '0;
    logic [1:0]  in_op = '0;
    logic        out_ready = 1'b0;
    logic        ir1, ir4, ov1, ov4;
    logic [15:0] od1, od4;
    logic [1:0]  st1, st4;
    logic        oz1, oz4;
    logic        sel = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    shift_unit_iter #(.WIDTH(16), .CNT_W(4), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_data(in_data),
        .in_cnt(in_cnt), .in_op(in_op), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .dbg_state(st1)
`ifdef SHIFT_ZERO_FLAG_EN
        , .out_zero(oz1)
`endif
    );

    shift_unit_iter #(.WIDTH(16), .CNT_W(4), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_data(in_data),
        .in_cnt(in_cnt), .in_op(in_op), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .dbg_state(st4)
`ifdef SHIFT_ZERO_FLAG_EN
        , .out_zero(oz4)
`endif
    );

`ifndef SHIFT_ZERO_FLAG_EN
    assign oz1 = 1'b0;
    assign oz4 = 1'b0;
`endif

    logic        cur_ir, cur_ov, cur_oz;
    logic [15:0] cur_od;
    assign cur_ir = sel ? ir4 : ir1;
    assign cur_ov = sel ? ov4 : ov1;
    assign cur_od = sel ? od4 : od1;
    assign cur_oz = sel ? oz4 : oz1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents a request at a negedge; it is accepted at the following posedge.
    task automatic start_op(input logic s4, input logic [1:0] op, input logic [15:0] d,
                            input logic [3:0] c, input string tag);
        @(negedge clk);
        sel = s4;
        in_op = op; in_data = d; in_cnt = c; out_ready = 1'b0;
        if (s4) v4 = 1'b1; else v1 = 1'b1;
        #1;
        check({tag, "_in_ready_idle"}, 32'(cur_ir), 32'd1);
        @(posedge clk);
        #1;
        v1 = 1'b0; v4 = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid appears, then checks result and latency.
    task automatic wait_done(input logic [15:0] exp, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        check({tag, "_busy"}, 32'(cur_ir), 32'd0);
        while (!cur_ov && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(cur_od), 32'(exp));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(cur_ir), 32'd1);
        check({tag, "_valid_after"}, 32'(cur_ov), 32'd0);
    endtask

    task automatic run(input logic s4, input logic [1:0] op, input logic [15:0] d,
                       input logic [3:0] c, input logic [15:0] exp, input int exp_lat,
                       input string tag);
        start_op(s4, op, d, c, tag);
        wait_done(exp, exp_lat, tag);
        release_result(tag);
    endtask

    initial begin
        logic [15:0] held;
        #12;
        check("reset_ready1", 32'(ir1), 32'd1);
        check("reset_valid1", 32'(ov1), 32'd0);
        check("reset_data1", 32'(od1), 32'd0);
        check("reset_ready4", 32'(ir4), 32'd1);
        check("reset_data4", 32'(od4), 32'd0);
`ifdef SHIFT_ZERO_FLAG_EN
        check("reset_zero1", 32'(oz1), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // op: 0 ROL, 1 SLL, 2 ROR, 3 SRA
        run(1'b0, 2'd0, 16'h8001, 4'd1,  16'h0003, 1,  "rol1_s1");
        run(1'b0, 2'd3, 16'h8000, 4'd15, 16'hFFFF, 15, "sra15_s1");
        run(1'b0, 2'd1, 16'h8000, 4'd0,  16'h8000, 0,  "sll0_s1");
        run(1'b0, 2'd2, 16'h0003, 4'd2,  16'hC000, 2,  "ror2_s1");
        run(1'b1, 2'd1, 16'h00FF, 4'd8,  16'hFF00, 2,  "sll8_s4");
        run(1'b1, 2'd2, 16'h0001, 4'd5,  16'h0800, 2,  "ror5_s4");
        run(1'b1, 2'd3, 16'h7000, 4'd3,  16'h0E00, 1,  "sra3_s4");
        run(1'b1, 2'd2, 16'h1234, 4'd15, 16'h2468, 4,  "ror15_s4");
        run(1'b1, 2'd0, 16'h8421, 4'd0,  16'h8421, 0,  "rol0_s4");

        // Zero flag: SLL clears the operand, ROL does not.
        start_op(1'b1, 2'd1, 16'h0100, 4'd8, "zsll");
        wait_done(16'h0000, 2, "zsll");
`ifdef SHIFT_ZERO_FLAG_EN
        check("zsll_zero", 32'(cur_oz), 32'd1);
`endif
        release_result("zsll");
        start_op(1'b1, 2'd0, 16'h0100, 4'd8, "zrol");
        wait_done(16'h0001, 2, "zrol");
`ifdef SHIFT_ZERO_FLAG_EN
        check("zrol_zero", 32'(cur_oz), 32'd0);
`endif
        release_result("zrol");

        // Backpressure: result held and new requests ignored while out_ready is low.
        start_op(1'b0, 2'd1, 16'h0003, 4'd3, "bp");
        wait_done(16'h0018, 3, "bp");
        held = 16'h0018;
        v1 = 1'b1; in_data = 16'hAAAA; in_cnt = 4'd0; in_op = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", 32'(ov1), 32'd1);
            check("bp_data_hold", 32'(od1), 32'(held));
            check("bp_in_ready", 32'(ir1), 32'd0);
        end
        v1 = 1'b0;
        release_result("bp");

        // Asynchronous reset in the middle of a long shift.
        start_op(1'b0, 2'd3, 16'hF000, 4'd12, "rst");
        repeat (5) @(negedge clk);
        check("rst_mid_busy", 32'(ir1), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(ov1), 32'd0);
        check("rst_data", 32'(od1), 32'd0);
        check("rst_ready", 32'(ir1), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 2'd0, 16'h1234, 4'd4, 16'h2341, 4, "post_rst_s1");
        run(1'b1, 2'd0, 16'h1234, 4'd4, 16'h2341, 1, "post_rst_s4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
